// File: rtl/mem_responder_if.sv
// Request/response bundle between control (master) and the memory responder (slave).
interface mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Read;
  logic                  Write;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] MDatain;
  logic                  mem_ready;
  logic                  busy;

  modport master (
    output Read, Write, addr, wdata,
    input  MDatain, mem_ready, busy
  );

  modport slave (
    input  Read, Write, addr, wdata,
    output MDatain, mem_ready, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: edge-detected Read/Write strobes, programmable wait states,
// single-cycle mem_ready completion pulse and registered read data.
//
// state    | meaning
// S_IDLE   | waiting for a strobe rising edge; requests accepted only here
// S_WAIT   | counting down the slow-memory wait states
// S_ACCESS | RAM read or write happens on this cycle's edge, mem_ready raised
// S_DONE   | mem_ready drops, one turnaround cycle before IDLE
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input logic               clk,
  input logic               clr,
  mem_responder_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    rd_hist_q, wr_hist_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    op_wr_q, op_wr_d;
  logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    mem_we;
  logic                    rd_req, wr_req;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Upper MAR bits alias onto the implemented words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH];

  assign rd_req = bus.Read  & ~rd_hist_q;
  assign wr_req = bus.Write & ~wr_hist_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_hist_q <= 1'b0;
      wr_hist_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      mdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_hist_q <= bus.Read;
      wr_hist_q <= bus.Write;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_wr_q   <= op_wr_d;
      mdata_q   <= mdata_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    mdata_d = mdata_q;
    ready_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A simultaneous read edge is dropped: the write takes priority.
        if (rd_req || wr_req) begin
          addr_d  = bus.addr[ADDR_WIDTH-1:0];
          wdata_d = bus.wdata;
          op_wr_d = wr_req;
          cnt_d   = CW'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (op_wr_q) mem_we  = 1'b1;
        else         mdata_d = mem[addr_q];
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // RAM contents survive clr; an aborted access never reaches S_ACCESS.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign bus.MDatain   = mdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.busy      = busy_q;

endmodule
